// File: rtl/uart_rx_deser.sv
// UART receive deserializer: oversamples the serial pin, rebuilds 8N1 frames
// LSB first, and hands each byte out through a one-entry valid/ready register.
module uart_rx_deser #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sig_rx,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BRK_WAIT
  } state_t;

  logic                  sync1_q;
  logic                  rx_s_q;
  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      bit_idx_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  frame_err_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  overrun_q;
  logic                  byte_done;

  // Synchronizer resets to 1 so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= sig_rx;
      rx_s_q  <= sync1_q;
    end
  end

  assign byte_done = (state_q == ST_STOP) && (cnt_q == CNT_LAST) && rx_s_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            state_q <= ST_START;
            cnt_q   <= '0;
          end
        end
        ST_START: begin
          // Mid-start re-check rejects glitches shorter than half a bit.
          if (cnt_q == CNT_HALF) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s_q ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q              <= '0;
            shift_q[bit_idx_q] <= rx_s_q;
            if (bit_idx_q == IDX_LAST) begin
              state_q <= ST_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + IDX_ONE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= ST_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_BRK_WAIT;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_BRK_WAIT: begin
          // A held-low line is a break, not a stream of start bits.
          if (rx_s_q) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (byte_done) begin
        // A simultaneous drain frees the slot, so the new byte can take it.
        if (!valid_q || ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Scoreboard bench for uart_rx_deser at 16 clocks per bit: the stimulus pushes
// expected bytes, a monitor pops them on every valid/ready transfer.
module tb_uart_rx_deser;

  localparam int CPB = 16;

  logic       clk;
  logic       rstn;
  logic       sig_rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  logic [7:0] exp_q[$];
  int         n_cmp;
  int         n_bad;
  int         fe_cnt;
  int         ov_cnt;

  uart_rx_deser #(
    .DATA_WIDTH(8),
    .BAUD_RATE (10),
    .CLK_FREQ  (160)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .sig_rx   (sig_rx),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Caller must be at a falling edge; returns at a falling edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    sig_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      sig_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    sig_rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #2 ready = v;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({"drain_", name}, exp_q.size(), 0);
  endtask

  // Monitor: pops on each transfer and counts single-cycle flag pulses.
  initial begin
    logic       fe_prev;
    logic       ov_prev;
    logic [7:0] e;
    fe_prev = 1'b0;
    ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (valid && ready) begin
          $display("rx byte %02h at t=%0t", data, $time);
          if (exp_q.size() == 0) begin
            check("unexpected_byte", int'(data), -1);
          end else begin
            e = exp_q.pop_front();
            check("rx_byte", int'(data), int'(e));
          end
        end
        if (frame_err) begin
          fe_cnt++;
          check("frame_err_single", int'(fe_prev), 0);
        end
        if (overrun) begin
          ov_cnt++;
          check("overrun_single", int'(ov_prev), 0);
        end
      end
      fe_prev = frame_err;
      ov_prev = overrun;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    fe_cnt = 0;
    ov_cnt = 0;
    ready  = 1'b1;
    sig_rx = 1'b1;
    rstn   = 1'b1;
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_data", int'(data), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_overrun", int'(overrun), 0);
    @(posedge clk);
    #2 rstn = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_drain("a5");

    // Back-to-back, zero idle bits
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h3C);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    wait_drain("b2b");

    // Short glitch must be rejected
    sig_rx = 1'b0;
    repeat (4) @(negedge clk);
    sig_rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_valid", int'(valid), 0);
    check("glitch_fe", fe_cnt, 0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_drain("5a");

    // Framing error followed by a break
    send_frame(8'h81, 1'b0);
    repeat (40) @(negedge clk);
    sig_rx = 1'b1;
    repeat (32) @(negedge clk);
    check("fe_count", fe_cnt, 1);
    check("fe_valid", int'(valid), 0);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    wait_drain("42");

    // Overrun: second byte dropped while the slot is full
    set_ready(1'b0);
    @(negedge clk);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (10) @(negedge clk);
    check("ovr_data", int'(data), 8'h11);
    check("ovr_valid", int'(valid), 1);
    check("ovr_count", ov_cnt, 1);
    set_ready(1'b1);
    wait_drain("ovr");
    repeat (3) @(negedge clk);
    check("ovr_valid_drop", int'(valid), 0);

    // Drain coincides with completion: slot refills, no overrun
    set_ready(1'b0);
    @(negedge clk);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (9 * CPB + CPB / 2 + 2) @(posedge clk);
        #2 ready = 1'b1;
        @(posedge clk);
        #2 ready = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check("swap_data", int'(data), 8'h22);
    check("swap_valid", int'(valid), 1);
    check("swap_ov_count", ov_cnt, 1);
    set_ready(1'b1);
    wait_drain("swap");

    // Reset mid-frame with a byte still held in the output register
    set_ready(1'b0);
    @(negedge clk);
    send_frame(8'h77, 1'b1);
    repeat (4) @(negedge clk);
    check("pre_rst_valid", int'(valid), 1);
    check("pre_rst_data", int'(data), 8'h77);
    fork
      send_frame(8'hC3, 1'b1);
      begin
        repeat (5 * CPB + CPB / 2) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("midrst_valid", int'(valid), 0);
        check("midrst_data", int'(data), 0);
        check("midrst_fe", int'(frame_err), 0);
        check("midrst_ov", int'(overrun), 0);
      end
    join
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    set_ready(1'b1);
    repeat (20) @(negedge clk);
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1);
    wait_drain("99");

    repeat (20) @(negedge clk);
    check("final_fe_count", fe_cnt, 1);
    check("final_ov_count", ov_cnt, 1);
    check("final_valid", int'(valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
